cle_param: RTL

Parametrised connected-component labeling engine, successor to the fixed 32x32 CLE. It reads a packed binary image from a synchronous ROM and writes one label per pixel into a synchronous SRAM. Image size, label width and connectivity (4/8) are configurable. Labels are deterministic: components are numbered 1..N in raster order of their first pixel, and background is 0. It sits between the image ROM and the result SRAM, under a top-level controller that issues `start` and waits for `finish`.

---
 rtl/cle_param.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cle_param.sv
// Two-pass connected-component labeler: raster scan with union-find equivalences,
// resolve to dense final labels, then rewrite every SRAM word with its final label.
module cle_param #(
  parameter  int IMG_W   = 32,
  parameter  int IMG_H   = 32,
  parameter  int LBL_W   = 8,
  parameter  int MAX_LBL = 255,
  localparam int ROM_AW  = $clog2(IMG_W*IMG_H/8),
  localparam int RAM_AW  = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              conn8,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [7:0]        rom_q,
  output logic [RAM_AW-1:0] sram_a,
  output logic [LBL_W-1:0]  sram_d,
  output logic              sram_wen,
  input  logic [LBL_W-1:0]  sram_q,
  output logic              busy,
  output logic              finish,
  output logic [LBL_W-1:0]  obj_cnt,
  output logic              ovf
);

  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int LBL_N = 2**LBL_W;
  localparam logic [XW-1:0]  X_LAST = XW'(IMG_W-1);
  localparam logic [YW-1:0]  Y_LAST = YW'(IMG_H-1);
  localparam logic [LBL_W:0] MAX_L  = (LBL_W+1)'(MAX_LBL);

  typedef logic [LBL_W-1:0] lbl_t;

  typedef enum logic [3:0] {
    S_IDLE, S_ROM_ADDR, S_ROM_DATA, S_GATHER, S_CHASE, S_SCAN_END,
    S_RESOLVE, S_RL_RD, S_RL_Q, S_RL_WR, S_DONE
  } state_t;

  state_t state, state_nx;

  logic           c8;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [7:0]     pix_byte;
  lbl_t           left_lbl;
  lbl_t           ul_lbl;
  lbl_t           nb   [4];
  lbl_t           orig [4];
  logic [LBL_W:0] next_lbl;
  logic [LBL_W:0] res_i;
  lbl_t           cnt;

  // NOTE: storage arrays carry no reset; every entry is written before it is read.
  lbl_t lb  [IMG_W];
  lbl_t eq  [LBL_N];
  lbl_t fin [LBL_N];

  logic          is_obj;
  logic [XW-1:0] x_nx;
  lbl_t          ri;
  lbl_t          g [4];
  logic          chase_done;
  logic          has_nb;
  lbl_t          min_root;
  logic          need_new;
  logic          ovf_hit;
  lbl_t          cur_lbl;
  logic          last_pix;
  logic          byte_end;

  assign is_obj   = pix_byte[7];
  assign x_nx     = x + 1'b1;
  assign ri       = res_i[LBL_W-1:0];
  assign last_pix = (x == X_LAST) && (y == Y_LAST);
  assign byte_end = (x[2:0] == 3'b111);

  // Raw neighbour labels: 0=left, 1=up-left, 2=up, 3=up-right; 0 means none.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int k = 0; k < 4; k++) g[k] = '0;
    if (is_obj) begin
      if (x != '0) g[0] = left_lbl;
      if (y != '0) begin
        g[2] = lb[x];
        if (c8 && x != '0)     g[1] = ul_lbl;
        if (c8 && x != X_LAST) g[3] = lb[x_nx];
      end
    end
  end

  always_comb begin
    chase_done = 1'b1;
    has_nb     = 1'b0;
    min_root   = '1;
    for (int k = 0; k < 4; k++) begin
      if (nb[k] != '0) begin
        has_nb = 1'b1;
        if (eq[nb[k]] != nb[k]) chase_done = 1'b0;
        if (nb[k] < min_root)   min_root   = nb[k];
      end
    end
  end

  assign need_new = is_obj && !has_nb;
  assign ovf_hit  = need_new && (next_lbl > MAX_L);
  assign cur_lbl  = !is_obj ? '0 : (has_nb ? min_root : next_lbl[LBL_W-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_ROM_ADDR;
      S_ROM_ADDR:     state_nx = S_ROM_DATA;
      S_ROM_DATA:     state_nx = S_GATHER;
      S_GATHER:       state_nx = S_CHASE;
      S_CHASE: begin
        if (chase_done) begin
          if (ovf_hit)       state_nx = S_DONE;
          else if (last_pix) state_nx = S_SCAN_END;
          else if (byte_end) state_nx = S_ROM_ADDR;
          else               state_nx = S_GATHER;
        end
      end
      S_SCAN_END:     state_nx = S_RESOLVE;
      S_RESOLVE:      if (res_i == next_lbl) state_nx = S_RL_RD;
      S_RL_RD:        state_nx = S_RL_Q;
      S_RL_Q:         state_nx = S_RL_WR;
      S_RL_WR:        state_nx = (sram_a == '1) ? S_DONE : S_RL_RD;
      default:        state_nx = S_IDLE;
    endcase
  end

  // Label tables. Besides merging roots, each raw neighbour label is pointed
  // straight at the winning root so later lookups stay short.
  always_ff @(posedge clk) begin
    if (state == S_CHASE && chase_done && !ovf_hit) begin
      lb[x] <= cur_lbl;
      if (need_new) eq[next_lbl[LBL_W-1:0]] <= next_lbl[LBL_W-1:0];
      for (int k = 0; k < 4; k++) begin
        if (orig[k] != '0) eq[orig[k]] <= min_root;
        if (nb[k] != '0)   eq[nb[k]]   <= min_root;
      end
    end
    if (state == S_RESOLVE && res_i != next_lbl)
      fin[ri] <= (eq[ri] == ri) ? cnt + 1'b1 : fin[eq[ri]];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      finish   <= 1'b0;
      ovf      <= 1'b0;
      obj_cnt  <= '0;
      rom_a    <= '0;
      sram_a   <= '0;
      sram_d   <= '0;
      sram_wen <= 1'b1;
      c8       <= 1'b0;
      x        <= '0;
      y        <= '0;
      pix_byte <= '0;
      left_lbl <= '0;
      ul_lbl   <= '0;
      next_lbl <= '0;
      res_i    <= '0;
      cnt      <= '0;
      for (int k = 0; k < 4; k++) begin
        nb[k]   <= '0;
        orig[k] <= '0;
      end
    end else begin
      sram_wen <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            busy     <= 1'b1;
            finish   <= 1'b0;
            ovf      <= 1'b0;
            obj_cnt  <= '0;
            c8       <= conn8;
            rom_a    <= '0;
            x        <= '0;
            y        <= '0;
            next_lbl <= (LBL_W+1)'(1);
            res_i    <= (LBL_W+1)'(1);
            cnt      <= '0;
          end
        end
        S_ROM_DATA: pix_byte <= rom_q;
        S_GATHER: begin
          for (int k = 0; k < 4; k++) begin
            orig[k] <= g[k];
            nb[k]   <= (g[k] == '0) ? '0 : eq[g[k]];
          end
        end
        S_CHASE: begin
          if (!chase_done) begin
            for (int k = 0; k < 4; k++)
              if (nb[k] != '0) nb[k] <= eq[nb[k]];
          end else if (ovf_hit) begin
            ovf    <= 1'b1;
            busy   <= 1'b0;
            finish <= 1'b1;
          end else begin
            sram_a   <= {y, x};
            sram_d   <= cur_lbl;
            sram_wen <= 1'b0;
            left_lbl <= cur_lbl;
            ul_lbl   <= lb[x];
            pix_byte <= {pix_byte[6:0], 1'b0};
            x        <= x_nx;
            if (x == X_LAST) y <= y + 1'b1;
            if (need_new) next_lbl <= next_lbl + 1'b1;
            if (byte_end && !last_pix) rom_a <= rom_a + 1'b1;
          end
        end
        S_RESOLVE: begin
          if (res_i != next_lbl) begin
            if (eq[ri] == ri) cnt <= cnt + 1'b1;
            res_i <= res_i + 1'b1;
          end else begin
            obj_cnt <= cnt;
            sram_a  <= '0;
          end
        end
        S_RL_Q: begin
          sram_d   <= (sram_q == '0) ? '0 : fin[sram_q];
          sram_wen <= 1'b0;
        end
        S_RL_WR: begin
          if (sram_a == '1) begin
            busy   <= 1'b0;
            finish <= 1'b1;
          end else begin
            sram_a <= sram_a + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
